multdiv_sequencer: RTL

Controller sequencing the shared multi-cycle multiply/divide unit for the 5-stage pipelined processor. Sits beside the execute stage: accepts a `mul`/`div` in D/X, stalls PC, F/D and D/X, issues a one-cycle start pulse to the multdiv datapath, waits for its ready, then returns the result (or the `r30` exception write) to the X/M input for that instruction.

---
 rtl/multdiv_sequencer_pkg.sv | 25 ++
 rtl/multdiv_sequencer_if.sv | 38 +++
 rtl/multdiv_sequencer_watchdog.sv | 32 +++
 rtl/multdiv_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the mul/div sequencer: FSM encoding, ALU opcodes and
// the r30 exception status codes written when the multdiv unit faults.
package md_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } md_state_t;

    localparam logic [4:0] MD_OP_MUL = 5'b00110;
    localparam logic [4:0] MD_OP_DIV = 5'b00111;

    localparam logic [4:0]        RSTATUS_REG = 5'd30;
    localparam logic [DATA_W-1:0] RSTATUS_MUL = 32'd4;
    localparam logic [DATA_W-1:0] RSTATUS_DIV = 32'd5;

    function automatic logic [DATA_W-1:0] rstatus_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Bundle between the execute stage / multdiv datapath (master) and the
// sequencer (slave).
interface multdiv_sequencer_if;
    import md_pkg::*;

    logic              op_valid;
    logic              op_is_div;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [4:0]        dest_reg;
    logic              md_ready;
    logic              md_exception;
    logic [DATA_W-1:0] md_result;
    logic [DATA_W-1:0] md_a;
    logic [DATA_W-1:0] md_b;
    logic              ctrl_mult;
    logic              ctrl_div;
    logic              stall;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic [4:0]        result_reg;
    logic              timeout_flag;

    modport slave (
        input  op_valid, op_is_div, operand_a, operand_b, dest_reg,
        input  md_ready, md_exception, md_result,
        output md_a, md_b, ctrl_mult, ctrl_div, stall,
        output result_valid, result_data, result_reg, timeout_flag
    );

    modport master (
        output op_valid, op_is_div, operand_a, operand_b, dest_reg,
        output md_ready, md_exception, md_result,
        input  md_a, md_b, ctrl_mult, ctrl_div, stall,
        input  result_valid, result_data, result_reg, timeout_flag
    );

endinterface

// File: rtl/multdiv_sequencer_watchdog.sv
// WAIT-state watchdog: cleared in ISSUE, counts WAIT cycles, flags the last
// allowed cycle. Only built when MD_TIMEOUT_EN is defined.
`ifdef MD_TIMEOUT_EN
module md_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // The FSM leaves WAIT on expiry, so the counter never needs to saturate.
    assign expire = enable && (count == LAST);

endmodule
`endif

// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div through the shared multdiv unit while stalling the front
// of the pipeline. Define MD_TIMEOUT_EN to add the WAIT-state watchdog.
module multdiv_sequencer
    import md_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                clock,
    input logic                reset,
    multdiv_sequencer_if.slave bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    md_state_t         state, state_nxt;
    logic [DATA_W-1:0] a_q, b_q;
    logic              is_div_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] res_data_q;
    logic [4:0]        res_reg_q;
    logic              wd_expire;
    logic              accept;

    assign accept = (state == IDLE) && bus.op_valid;

`ifdef MD_TIMEOUT_EN
    logic timeout_q;

    md_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT),
        .expire (wd_expire)
    );

    // Only a watchdog expiry without a same-cycle ready counts as a timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timeout_q <= 1'b0;
        else if ((state == WAIT) && !bus.md_ready && wd_expire)
            timeout_q <= 1'b1;
    end

    assign bus.timeout_flag = timeout_q;
`else
    assign wd_expire        = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.op_valid) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (bus.md_ready || wd_expire) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            is_div_q   <= 1'b0;
            rd_q       <= '0;
            res_data_q <= '0;
            res_reg_q  <= '0;
        end else begin
            if (accept) begin
                a_q      <= bus.operand_a;
                b_q      <= bus.operand_b;
                is_div_q <= bus.op_is_div;
                rd_q     <= bus.dest_reg;
            end
            // Faults and timeouts both redirect the write to r30 with a status code.
            if (state == WAIT) begin
                if (bus.md_ready && !bus.md_exception) begin
                    res_data_q <= bus.md_result;
                    res_reg_q  <= rd_q;
                end else if (bus.md_ready || wd_expire) begin
                    res_data_q <= rstatus_code(is_div_q);
                    res_reg_q  <= RSTATUS_REG;
                end
            end
        end
    end

    assign bus.stall        = accept || (state == ISSUE) || (state == WAIT);
    assign bus.ctrl_div     = (state == ISSUE) && is_div_q;
    assign bus.ctrl_mult    = (state == ISSUE) && !is_div_q;
    assign bus.result_valid = (state == DONE);
    assign bus.result_data  = res_data_q;
    assign bus.result_reg   = res_reg_q;
    assign bus.md_a         = a_q;
    assign bus.md_b         = b_q;

endmodule
